clock_set_controller: RTL and testbench
=======================================

// Module: clock_set_controller
// PURPOSE
//  Time-keeping and time-set controller for the 7-segment MM:SS clock. It owns the seconds and minutes registers.
//  It sequences them through RUN / SET_MIN / SET_SEC modes from two debounced push-buttons, and generates the 1 Hz count enable.
//  Its outputs feed the digit separator and scan mux, with per-digit blank flags that make the field being set blink.
// PARAMETERS
//  DEBOUNCE_CYCLES  1_000_000    consecutive stable clk cycles before a button level is accepted (10 ms @ 100 MHz)
//  TICK_DIV         100_000_000  clk cycles per 1 s count tick
//  BLINK_DIV        50_000_000   clk cycles per blink phase toggle (0.5 s)
// PORTS
//  clk          in   1  system clock, 100 MHz
//  reset        in   1  asynchronous, active-high reset
//  mode_btn     in   1  raw mode push-button, active-high, asynchronous to clk
//  inc_btn      in   1  raw increment push-button, active-high, asynchronous to clk
//  clear_btn    in   1  raw clear push-button, active-high, asynchronous to clk
//  seconds      out  6  current seconds, 0..59
//  minutes      out  6  current minutes, 0..59
//  mode         out  2  00 RUN, 01 SET_MIN, 10 SET_SEC; 11 never driven
//  tick_pulse   out  1  one-cycle pulse on each 1 s count tick (RUN only)
//  digit_blank  out  4  [3] upper min, [2] lower min, [1] upper sec, [0] lower sec; 1 = blank
// BEHAVIOUR
//  Reset (async, immediate): seconds=0, minutes=0, mode=RUN, tick_pulse=0, digit_blank=0000.
//   Tick counter=0, blink_phase=1, all debounced levels=0, all debounce counters=0.
//  Button path, per button:
//   - 2-FF synchronizer.
//   - Debounce counter counts consecutive cycles where synced != debounced level. It clears when they match.
//   - When the count reaches DEBOUNCE_CYCLES, the debounced level flips and the counter clears.
//   - A press event is a one-cycle pulse in the cycle after the debounced level rises. No event on release.
//   - A held button gives exactly one event. No auto-repeat.
//  Tick generator:
//   - Counts 0..TICK_DIV-1 in RUN only. tick_pulse=1 in the cycle the count equals TICK_DIV-1, then the count wraps to 0.
//   - In SET_MIN and SET_SEC the count is held at 0 and tick_pulse=0.
//  FSM, advanced by a mode press: RUN -> SET_MIN -> SET_SEC -> RUN.
//   - On entry to RUN the tick count is 0, so the first tick comes TICK_DIV cycles later.
//  RUN, on tick_pulse (registers update on the same edge that ends the pulse cycle):
//   - seconds+1. If seconds was 59: seconds=0 and minutes+1.
//   - minutes wraps 59->0, so 59:59 -> 00:00.
//  SET_MIN: inc press -> minutes=(minutes+1) mod 60. Seconds unchanged.
//  SET_SEC: inc press -> seconds=(seconds+1) mod 60. No carry into minutes.
//  RUN: inc press ignored.
//  Clear press, any mode: seconds=0 and minutes=0. Mode unchanged. Tick count cleared to 0.
//  Simultaneous events in one cycle: priority is clear > mode > inc.
//   - Lower-priority events in that cycle are discarded.
//   - Clear+mode: registers clear AND the mode advances.
//  Blink:
//   - blink_phase is set to 1 on every mode change.
//   - In SET states it toggles every BLINK_DIV cycles.
//   - In RUN it is held at 1.
//  digit_blank:
//   - SET_MIN: 1100 when blink_phase=0, else 0000.
//   - SET_SEC: 0011 when blink_phase=0, else 0000.
//   - RUN: always 0000.
//  All outputs are registered. Mode, seconds and minutes change on the clk edge after the press-event cycle.
//  Arithmetic: 6-bit compares against 59. Values >59 cannot occur; no saturation logic is required.
// TESTING (bench params: DEBOUNCE_CYCLES=4, TICK_DIV=10, BLINK_DIV=8)
//  1. Release reset, all buttons 0 -> 00:00 and mode=00.
//     - tick_pulse every 10 cycles; seconds=1 after the first tick.
//     - Run to 00:59, one tick -> 01:00. Run to 59:59, one tick -> 00:00.
//  2. inc_btn in SET_MIN:
//     - High for 3 cycles, then low -> no event, minutes unchanged.
//     - High for 100 cycles -> exactly one minutes increment.
//  3. Mode press -> mode=01, tick_pulse stays 0.
//     - 3 inc presses -> minutes=3, seconds frozen.
//     - Mode press -> mode=10. Set seconds to 59, inc press -> seconds=0, minutes still 3.
//     - Mode press -> mode=00. Next seconds increment exactly 10 cycles later.
//  4. Blink:
//     - SET_MIN -> digit_blank alternates 0000/1100 every 8 cycles.
//     - SET_SEC -> alternates 0000/0011.
//     - RUN -> constant 0000.
//  5. Same-cycle debounced events:
//     - mode+inc in SET_MIN -> mode=10, minutes unchanged.
//     - clear+inc in SET_SEC at 12:34 -> 00:00, mode=10.
//  6. Assert reset mid-SET_SEC, between clk edges:
//     - Outputs go to 00:00, mode=00, digit_blank=0000 before the next edge.
//     - After release, counting resumes from 0.

Source files
------------

// File: rtl/clock_set_controller.sv
// ---------------------------------------------------------------------------
// clock_set_controller
//
// Time-keeping and time-set controller for a 7-segment MM:SS clock. It owns
// the seconds and minutes registers, steps them through RUN / SET_MIN /
// SET_SEC from debounced push-buttons, generates the 1 s count tick and
// produces per-digit blank flags so that the field being set blinks.
//
// Ports
//   clk          in   1  system clock
//   reset        in   1  asynchronous, active-high reset
//   mode_btn     in   1  raw mode button (async, active-high)
//   inc_btn      in   1  raw increment button (async, active-high)
//   clear_btn    in   1  raw clear button (async, active-high)
//   seconds      out  6  current seconds, 0..59
//   minutes      out  6  current minutes, 0..59
//   mode         out  2  00 RUN, 01 SET_MIN, 10 SET_SEC (FSM state)
//   tick_pulse   out  1  one-cycle pulse per 1 s count tick, RUN only
//   digit_blank  out  4  [3] upper min, [2] lower min, [1] upper sec,
//                        [0] lower sec; 1 = blank
//
// Button events are single-cycle strobes (no handshake). Each strobe is
// consumed in the cycle it is high; the registered effect is visible after
// the next clk edge. Simultaneous strobes resolve clear > mode > inc.
// ---------------------------------------------------------------------------

// ---------------------------------------------------------------------------
// clock_set_controller_debounce
//
// One button path: 2-FF synchronizer, level debouncer and rising-edge event.
//
// Ports
//   clk    in   1  system clock
//   reset  in   1  asynchronous, active-high reset
//   raw    in   1  raw button level, asynchronous to clk
//   press  out  1  one-cycle pulse in the cycle after the debounced level rises
// ---------------------------------------------------------------------------
module clock_set_controller_debounce #(
  parameter int CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic press
);

  localparam int CW = $clog2(CYCLES + 1);

  logic          sync1;
  logic          sync2;
  logic          level;
  logic          level_d;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1   <= 1'b0;
      sync2   <= 1'b0;
      level   <= 1'b0;
      level_d <= 1'b0;
      cnt     <= '0;
    end else begin
      sync1   <= raw;
      sync2   <= sync1;
      level_d <= level;
      // The counter measures how long the synchronized input has disagreed
      // with the accepted level; any agreement restarts the measurement.
      if (sync2 == level) begin
        cnt <= '0;
      end else if (cnt == CW'(CYCLES - 1)) begin
        cnt   <= '0;
        level <= ~level;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

  // Rising edge of the accepted level only; a held button yields one event.
  assign press = level & ~level_d;

endmodule

module clock_set_controller #(
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int TICK_DIV        = 100_000_000,
  parameter int BLINK_DIV       = 50_000_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       mode_btn,
  input  logic       inc_btn,
  input  logic       clear_btn,
  output logic [5:0] seconds,
  output logic [5:0] minutes,
  output logic [1:0] mode,
  output logic       tick_pulse,
  output logic [3:0] digit_blank
);

  localparam int TW = (TICK_DIV  > 1) ? $clog2(TICK_DIV)  : 1;
  localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  typedef enum logic [1:0] {
    RUN     = 2'b00,
    SET_MIN = 2'b01,
    SET_SEC = 2'b10
  } mode_t;

  // -------------------------------------------------------------------------
  // Button paths
  // -------------------------------------------------------------------------
  logic mode_evt;
  logic inc_evt;
  logic clear_evt;

  clock_set_controller_debounce #(.CYCLES(DEBOUNCE_CYCLES)) u_mode_db (
    .clk   (clk),
    .reset (reset),
    .raw   (mode_btn),
    .press (mode_evt)
  );

  clock_set_controller_debounce #(.CYCLES(DEBOUNCE_CYCLES)) u_inc_db (
    .clk   (clk),
    .reset (reset),
    .raw   (inc_btn),
    .press (inc_evt)
  );

  clock_set_controller_debounce #(.CYCLES(DEBOUNCE_CYCLES)) u_clear_db (
    .clk   (clk),
    .reset (reset),
    .raw   (clear_btn),
    .press (clear_evt)
  );

  // -------------------------------------------------------------------------
  // Mode FSM
  // -------------------------------------------------------------------------
  mode_t state;
  mode_t state_next;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= RUN;
    end else begin
      state <= state_next;
    end
  end

  // A clear in the same cycle does not block the mode advance.
  always_comb begin
    state_next = state;
    if (mode_evt) begin
      case (state)
        RUN:     state_next = SET_MIN;
        SET_MIN: state_next = SET_SEC;
        SET_SEC: state_next = RUN;
        default: state_next = RUN;
      endcase
    end
  end

  assign mode = state;

  // -------------------------------------------------------------------------
  // Datapath: time registers, tick generator, blink generator
  // -------------------------------------------------------------------------
  logic [TW-1:0] tick_cnt;
  logic [TW-1:0] tick_cnt_next;
  logic          tick_pulse_next;
  logic [BW-1:0] blink_cnt;
  logic [BW-1:0] blink_cnt_next;
  logic          blink_phase;
  logic          blink_phase_next;
  logic [5:0]    seconds_next;
  logic [5:0]    minutes_next;
  logic [3:0]    digit_blank_next;
  logic          mode_change;
  logic          inc_ok;

  assign mode_change = (state_next != state);
  // inc only acts when no higher-priority event shares its cycle.
  assign inc_ok      = inc_evt & ~clear_evt & ~mode_evt;

  // Seconds / minutes
  always_comb begin
    seconds_next = seconds;
    minutes_next = minutes;
    if (clear_evt) begin
      seconds_next = 6'd0;
      minutes_next = 6'd0;
    end else if ((state == RUN) && tick_pulse) begin
      // tick_pulse marks the last cycle of a second; the carry lands on the
      // edge that ends that cycle.
      if (seconds == 6'd59) begin
        seconds_next = 6'd0;
        minutes_next = (minutes == 6'd59) ? 6'd0 : minutes + 6'd1;
      end else begin
        seconds_next = seconds + 6'd1;
      end
    end else if (inc_ok && (state == SET_MIN)) begin
      minutes_next = (minutes == 6'd59) ? 6'd0 : minutes + 6'd1;
    end else if (inc_ok && (state == SET_SEC)) begin
      seconds_next = (seconds == 6'd59) ? 6'd0 : seconds + 6'd1;
    end
  end

  // Tick generator. The count only runs while staying in RUN, so entry to
  // RUN starts from 0 and the first tick lands a full TICK_DIV later.
  always_comb begin
    tick_cnt_next = '0;
    if (!clear_evt && (state == RUN) && (state_next == RUN)) begin
      if (tick_cnt == TW'(TICK_DIV - 1)) begin
        tick_cnt_next = '0;
      end else begin
        tick_cnt_next = tick_cnt + TW'(1);
      end
    end
    // Registered pulse: high exactly while the count sits at TICK_DIV-1.
    tick_pulse_next = (state_next == RUN) && (tick_cnt_next == TW'(TICK_DIV - 1));
  end

  // Blink generator: restarts visible (phase 1) on every mode change.
  always_comb begin
    blink_cnt_next   = '0;
    blink_phase_next = 1'b1;
    if (!mode_change && (state != RUN)) begin
      if (blink_cnt == BW'(BLINK_DIV - 1)) begin
        blink_cnt_next   = '0;
        blink_phase_next = ~blink_phase;
      end else begin
        blink_cnt_next   = blink_cnt + BW'(1);
        blink_phase_next = blink_phase;
      end
    end
  end

  // Blank flags follow the next-cycle state so they stay aligned with it.
  always_comb begin
    digit_blank_next = 4'b0000;
    if (!blink_phase_next) begin
      case (state_next)
        SET_MIN: digit_blank_next = 4'b1100;
        SET_SEC: digit_blank_next = 4'b0011;
        default: digit_blank_next = 4'b0000;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      seconds     <= 6'd0;
      minutes     <= 6'd0;
      tick_cnt    <= '0;
      tick_pulse  <= 1'b0;
      blink_cnt   <= '0;
      blink_phase <= 1'b1;
      digit_blank <= 4'b0000;
    end else begin
      seconds     <= seconds_next;
      minutes     <= minutes_next;
      tick_cnt    <= tick_cnt_next;
      tick_pulse  <= tick_pulse_next;
      blink_cnt   <= blink_cnt_next;
      blink_phase <= blink_phase_next;
      digit_blank <= digit_blank_next;
    end
  end

endmodule

// File: tb/tb_clock_set_controller.sv
// ---------------------------------------------------------------------------
// tb_clock_set_controller
//
// Directed bench for clock_set_controller with DEBOUNCE_CYCLES=4,
// TICK_DIV=10, BLINK_DIV=8. Inputs are driven and outputs sampled on the
// falling clock edge; the DUT acts on the rising edge.
// ---------------------------------------------------------------------------
module tb_clock_set_controller;

  logic       clk = 1'b0;
  logic       reset;
  logic       mode_btn;
  logic       inc_btn;
  logic       clear_btn;
  logic [5:0] seconds;
  logic [5:0] minutes;
  logic [1:0] mode;
  logic       tick_pulse;
  logic [3:0] digit_blank;

  int checks   = 0;
  int failures = 0;

  clock_set_controller #(
    .DEBOUNCE_CYCLES (4),
    .TICK_DIV        (10),
    .BLINK_DIV       (8)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .mode_btn    (mode_btn),
    .inc_btn     (inc_btn),
    .clear_btn   (clear_btn),
    .seconds     (seconds),
    .minutes     (minutes),
    .mode        (mode),
    .tick_pulse  (tick_pulse),
    .digit_blank (digit_blank)
  );

  // Clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Driver tasks
  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // which: 0 mode, 1 inc, 2 clear. Long enough to debounce press and release.
  task automatic press(input int which);
    case (which)
      0: mode_btn  = 1'b1;
      1: inc_btn   = 1'b1;
      default: clear_btn = 1'b1;
    endcase
    idle(6);
    mode_btn  = 1'b0;
    inc_btn   = 1'b0;
    clear_btn = 1'b0;
    idle(10);
  endtask

  task automatic press_n(input int which, input int n);
    for (int i = 0; i < n; i++) press(which);
  endtask

  // Holds mode until the expected mode shows up (bounded); returns at the
  // first sample after the changing edge.
  task automatic enter_mode(input logic [1:0] target, output bit ok);
    ok = 1'b0;
    mode_btn = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (mode === target) begin
        ok = 1'b1;
        break;
      end
    end
    mode_btn = 1'b0;
  endtask

  // Tests
  task automatic test_reset;
    reset = 1'b1; mode_btn = 1'b0; inc_btn = 1'b0; clear_btn = 1'b0;
    idle(3);
    checks++; if (seconds !== 6'd0) begin failures++; $display("FAIL reset_sec: got %0d expected 0", seconds); end
    checks++; if (minutes !== 6'd0) begin failures++; $display("FAIL reset_min: got %0d expected 0", minutes); end
    checks++; if (mode !== 2'b00) begin failures++; $display("FAIL reset_mode: got %b expected 00", mode); end
    checks++; if (tick_pulse !== 1'b0) begin failures++; $display("FAIL reset_tick: got %b expected 0", tick_pulse); end
    checks++; if (digit_blank !== 4'b0000) begin failures++; $display("FAIL reset_blank: got %b expected 0000", digit_blank); end
    reset = 1'b0;
  endtask

  // Sample k is taken after the k-th rising edge following reset release.
  task automatic test_run_count;
    logic [5:0] exp_s;
    logic       exp_p;
    for (int k = 1; k <= 36000; k++) begin
      @(negedge clk);
      if (k <= 30) begin
        exp_p = ((k % 10) == 9);
        exp_s = 6'(k / 10);
        checks++; if (tick_pulse !== exp_p) begin failures++; $display("FAIL run_tick k=%0d: got %b expected %b", k, tick_pulse, exp_p); end
        checks++; if (seconds !== exp_s) begin failures++; $display("FAIL run_sec k=%0d: got %0d expected %0d", k, seconds, exp_s); end
      end
      if (k == 599) begin
        checks++; if ({minutes, seconds} !== {6'd0, 6'd59}) begin failures++; $display("FAIL run_0059: got %0d:%0d expected 0:59", minutes, seconds); end
      end
      if (k == 600) begin
        checks++; if ({minutes, seconds} !== {6'd1, 6'd0}) begin failures++; $display("FAIL run_0100: got %0d:%0d expected 1:0", minutes, seconds); end
      end
      if (k == 35999) begin
        checks++; if ({minutes, seconds} !== {6'd59, 6'd59}) begin failures++; $display("FAIL run_5959: got %0d:%0d expected 59:59", minutes, seconds); end
      end
      if (k == 36000) begin
        checks++; if ({minutes, seconds} !== {6'd0, 6'd0}) begin failures++; $display("FAIL run_wrap: got %0d:%0d expected 0:0", minutes, seconds); end
      end
    end
  endtask

  task automatic test_set_sequence;
    bit ok;
    enter_mode(2'b01, ok);
    checks++; if (!ok) begin failures++; $display("FAIL seq_to_set_min: mode %b expected 01", mode); end
    idle(12);
    press(2);
    press_n(1, 3);
    checks++; if ({minutes, seconds} !== {6'd3, 6'd0}) begin failures++; $display("FAIL seq_min3: got %0d:%0d expected 3:0", minutes, seconds); end
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      checks++; if (tick_pulse !== 1'b0) begin failures++; $display("FAIL seq_no_tick i=%0d: got %b expected 0", i, tick_pulse); end
    end
    checks++; if (seconds !== 6'd0) begin failures++; $display("FAIL seq_sec_frozen: got %0d expected 0", seconds); end
    enter_mode(2'b10, ok);
    checks++; if (!ok) begin failures++; $display("FAIL seq_to_set_sec: mode %b expected 10", mode); end
    idle(12);
    press_n(1, 59);
    checks++; if ({minutes, seconds} !== {6'd3, 6'd59}) begin failures++; $display("FAIL seq_sec59: got %0d:%0d expected 3:59", minutes, seconds); end
    press(1);
    checks++; if ({minutes, seconds} !== {6'd3, 6'd0}) begin failures++; $display("FAIL seq_sec_wrap: got %0d:%0d expected 3:0", minutes, seconds); end
    enter_mode(2'b00, ok);
    checks++; if (!ok) begin failures++; $display("FAIL seq_to_run: mode %b expected 00", mode); end
    for (int k = 0; k <= 10; k++) begin
      if (k > 0) @(negedge clk);
      if (k == 9) begin
        checks++; if (tick_pulse !== 1'b1) begin failures++; $display("FAIL seq_first_tick: got %b expected 1", tick_pulse); end
        checks++; if (seconds !== 6'd0) begin failures++; $display("FAIL seq_sec_before: got %0d expected 0", seconds); end
      end
      if (k == 10) begin
        checks++; if (seconds !== 6'd1) begin failures++; $display("FAIL seq_sec_after: got %0d expected 1", seconds); end
      end
    end
  endtask

  task automatic test_inc_filter;
    bit ok;
    enter_mode(2'b01, ok);
    checks++; if (!ok) begin failures++; $display("FAIL filt_to_set_min: mode %b expected 01", mode); end
    idle(12);
    press(2);
    inc_btn = 1'b1;
    idle(3);
    inc_btn = 1'b0;
    idle(10);
    checks++; if (minutes !== 6'd0) begin failures++; $display("FAIL filt_glitch: got %0d expected 0", minutes); end
    inc_btn = 1'b1;
    idle(100);
    inc_btn = 1'b0;
    idle(12);
    checks++; if ({minutes, seconds} !== {6'd1, 6'd0}) begin failures++; $display("FAIL filt_hold: got %0d:%0d expected 1:0", minutes, seconds); end
  endtask

  task automatic test_blink;
    bit         ok;
    logic [3:0] exp_b;
    enter_mode(2'b10, ok);
    checks++; if (!ok) begin failures++; $display("FAIL blink_to_set_sec: mode %b expected 10", mode); end
    for (int k = 0; k < 32; k++) begin
      if (k > 0) @(negedge clk);
      exp_b = (((k / 8) % 2) == 1) ? 4'b0011 : 4'b0000;
      checks++; if (digit_blank !== exp_b) begin failures++; $display("FAIL blink_sec k=%0d: got %b expected %b", k, digit_blank, exp_b); end
    end
    enter_mode(2'b00, ok);
    checks++; if (!ok) begin failures++; $display("FAIL blink_to_run: mode %b expected 00", mode); end
    for (int k = 0; k < 32; k++) begin
      if (k > 0) @(negedge clk);
      checks++; if (digit_blank !== 4'b0000) begin failures++; $display("FAIL blink_run k=%0d: got %b expected 0000", k, digit_blank); end
    end
    enter_mode(2'b01, ok);
    checks++; if (!ok) begin failures++; $display("FAIL blink_to_set_min: mode %b expected 01", mode); end
    for (int k = 0; k < 32; k++) begin
      if (k > 0) @(negedge clk);
      exp_b = (((k / 8) % 2) == 1) ? 4'b1100 : 4'b0000;
      checks++; if (digit_blank !== exp_b) begin failures++; $display("FAIL blink_min k=%0d: got %b expected %b", k, digit_blank, exp_b); end
    end
    idle(12);
  endtask

  task automatic test_simultaneous;
    press(2);
    press_n(1, 12);
    checks++; if ({minutes, seconds} !== {6'd12, 6'd0}) begin failures++; $display("FAIL simul_set12: got %0d:%0d expected 12:0", minutes, seconds); end
    mode_btn = 1'b1; inc_btn = 1'b1;
    idle(6);
    mode_btn = 1'b0; inc_btn = 1'b0;
    idle(12);
    checks++; if (mode !== 2'b10) begin failures++; $display("FAIL simul_mode_inc_mode: got %b expected 10", mode); end
    checks++; if (minutes !== 6'd12) begin failures++; $display("FAIL simul_mode_inc_min: got %0d expected 12", minutes); end
    press_n(1, 34);
    checks++; if ({minutes, seconds} !== {6'd12, 6'd34}) begin failures++; $display("FAIL simul_1234: got %0d:%0d expected 12:34", minutes, seconds); end
    clear_btn = 1'b1; inc_btn = 1'b1;
    idle(6);
    clear_btn = 1'b0; inc_btn = 1'b0;
    idle(12);
    checks++; if ({minutes, seconds} !== {6'd0, 6'd0}) begin failures++; $display("FAIL simul_clear_inc: got %0d:%0d expected 0:0", minutes, seconds); end
    checks++; if (mode !== 2'b10) begin failures++; $display("FAIL simul_clear_mode: got %b expected 10", mode); end
  endtask

  task automatic test_reset_mid;
    bit found;
    press(1);
    checks++; if (seconds !== 6'd1) begin failures++; $display("FAIL mid_pre_sec: got %0d expected 1", seconds); end
    found = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (digit_blank === 4'b0011) begin
        found = 1'b1;
        break;
      end
    end
    checks++; if (!found) begin failures++; $display("FAIL mid_blank_seen: got %b expected 0011 within 20 cycles", digit_blank); end
    #2;
    reset = 1'b1;
    #1;
    checks++; if ({minutes, seconds} !== {6'd0, 6'd0}) begin failures++; $display("FAIL mid_time: got %0d:%0d expected 0:0", minutes, seconds); end
    checks++; if (mode !== 2'b00) begin failures++; $display("FAIL mid_mode: got %b expected 00", mode); end
    checks++; if (digit_blank !== 4'b0000) begin failures++; $display("FAIL mid_blank: got %b expected 0000", digit_blank); end
    idle(2);
    reset = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (k == 9) begin
        checks++; if (tick_pulse !== 1'b1) begin failures++; $display("FAIL mid_tick: got %b expected 1", tick_pulse); end
      end
      if (k == 10) begin
        checks++; if (seconds !== 6'd1) begin failures++; $display("FAIL mid_resume: got %0d expected 1", seconds); end
      end
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_run_count();
    test_set_sequence();
    test_inc_filter();
    test_blink();
    test_simultaneous();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
